// File: rtl/alu_regread_stage_if.sv
// Bundle between the ALU issue unit / PRF / bypass network / execute stage and the register-read
// stage. The stage sits on the slave modport; the surrounding pipeline drives the master side.
interface alu_regread_stage_if #(
  parameter int unsigned PRF_AW = 6,
  parameter int unsigned XLEN   = 32,
  parameter int unsigned PC_W   = 32,
  parameter int unsigned OPW    = 6
) ();

  logic              flush;

  // Issue bundle, one set per lane
  logic              issue_en_0,  issue_en_1;
  logic [PRF_AW-1:0] op0PAddr_0,  op0PAddr_1;
  logic [PRF_AW-1:0] op1PAddr_0,  op1PAddr_1;
  logic [PRF_AW-1:0] dstPAddr_0,  dstPAddr_1;
  logic              dstwe_0,     dstwe_1;
  logic [PC_W-1:0]   pc_0,        pc_1;
  logic [OPW-1:0]    aluop_0,     aluop_1;
  logic [XLEN-1:0]   imm_0,       imm_1;
  logic              useImm_0,    useImm_1;
  logic              rr_ready;

  // PRF read ports: 0/1 = lane0 op0/op1, 2/3 = lane1 op0/op1
  logic [PRF_AW-1:0] prf_raddr_0, prf_raddr_1, prf_raddr_2, prf_raddr_3;
  logic [XLEN-1:0]   prf_rdata_0, prf_rdata_1, prf_rdata_2, prf_rdata_3;

  // ALU result bypass
  logic              wb_en_0,     wb_en_1;
  logic [PRF_AW-1:0] wb_addr_0,   wb_addr_1;
  logic [XLEN-1:0]   wb_data_0,   wb_data_1;

  // Execute-stage side
  logic              ex_ready;
  logic              ex_valid_0,  ex_valid_1;
  logic [XLEN-1:0]   ex_src0_0,   ex_src0_1;
  logic [XLEN-1:0]   ex_src1_0,   ex_src1_1;
  logic [PRF_AW-1:0] ex_dst_0,    ex_dst_1;
  logic              ex_dstwe_0,  ex_dstwe_1;
  logic [PC_W-1:0]   ex_pc_0,     ex_pc_1;
  logic [OPW-1:0]    ex_aluop_0,  ex_aluop_1;

  modport master (
    output flush,
    output issue_en_0, issue_en_1, op0PAddr_0, op0PAddr_1, op1PAddr_0, op1PAddr_1,
    output dstPAddr_0, dstPAddr_1, dstwe_0, dstwe_1, pc_0, pc_1, aluop_0, aluop_1,
    output imm_0, imm_1, useImm_0, useImm_1,
    input  rr_ready,
    input  prf_raddr_0, prf_raddr_1, prf_raddr_2, prf_raddr_3,
    output prf_rdata_0, prf_rdata_1, prf_rdata_2, prf_rdata_3,
    output wb_en_0, wb_en_1, wb_addr_0, wb_addr_1, wb_data_0, wb_data_1,
    output ex_ready,
    input  ex_valid_0, ex_valid_1, ex_src0_0, ex_src0_1, ex_src1_0, ex_src1_1,
    input  ex_dst_0, ex_dst_1, ex_dstwe_0, ex_dstwe_1, ex_pc_0, ex_pc_1,
    input  ex_aluop_0, ex_aluop_1
  );

  modport slave (
    input  flush,
    input  issue_en_0, issue_en_1, op0PAddr_0, op0PAddr_1, op1PAddr_0, op1PAddr_1,
    input  dstPAddr_0, dstPAddr_1, dstwe_0, dstwe_1, pc_0, pc_1, aluop_0, aluop_1,
    input  imm_0, imm_1, useImm_0, useImm_1,
    output rr_ready,
    output prf_raddr_0, prf_raddr_1, prf_raddr_2, prf_raddr_3,
    input  prf_rdata_0, prf_rdata_1, prf_rdata_2, prf_rdata_3,
    input  wb_en_0, wb_en_1, wb_addr_0, wb_addr_1, wb_data_0, wb_data_1,
    input  ex_ready,
    output ex_valid_0, ex_valid_1, ex_src0_0, ex_src0_1, ex_src1_0, ex_src1_1,
    output ex_dst_0, ex_dst_1, ex_dstwe_0, ex_dstwe_1, ex_pc_0, ex_pc_1,
    output ex_aluop_0, ex_aluop_1
  );

endinterface

// File: rtl/alu_regread_stage.sv
// Dual-lane ALU register-read stage: drives PRF read addresses, resolves operands through a
// two-port result bypass and registers the uops into execute under a ready/valid stall and flush.
module alu_regread_stage #(
  parameter int unsigned PRF_AW = 6,
  parameter int unsigned XLEN   = 32,
  parameter int unsigned PC_W   = 32,
  parameter int unsigned OPW    = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  alu_regread_stage_if.slave   bus
);

  logic              rr_ready;
  logic              wb_en_0, wb_en_1;
  logic [PRF_AW-1:0] wb_addr_0, wb_addr_1;
  logic [XLEN-1:0]   wb_data_0, wb_data_1;

  logic [XLEN-1:0]   src0_sel [2];
  logic [XLEN-1:0]   src1_sel [2];

  logic [1:0]        ex_valid_d, ex_valid_q;
  logic [1:0]        ex_dstwe_d, ex_dstwe_q;
  logic [XLEN-1:0]   ex_src0_d  [2];
  logic [XLEN-1:0]   ex_src0_q  [2];
  logic [XLEN-1:0]   ex_src1_d  [2];
  logic [XLEN-1:0]   ex_src1_q  [2];
  logic [PRF_AW-1:0] ex_dst_d   [2];
  logic [PRF_AW-1:0] ex_dst_q   [2];
  logic [PC_W-1:0]   ex_pc_d    [2];
  logic [PC_W-1:0]   ex_pc_q    [2];
  logic [OPW-1:0]    ex_aluop_d [2];
  logic [OPW-1:0]    ex_aluop_q [2];

  assign wb_en_0   = bus.wb_en_0;
  assign wb_en_1   = bus.wb_en_1;
  assign wb_addr_0 = bus.wb_addr_0;
  assign wb_addr_1 = bus.wb_addr_1;
  assign wb_data_0 = bus.wb_data_0;
  assign wb_data_1 = bus.wb_data_1;

  // Port 0 has priority when both bypass ports match the same register.
  function automatic logic [XLEN-1:0] bypass(input logic [PRF_AW-1:0] addr,
                                             input logic [XLEN-1:0]   prf);
    if (wb_en_0 && (wb_addr_0 == addr)) begin
      return wb_data_0;
    end else if (wb_en_1 && (wb_addr_1 == addr)) begin
      return wb_data_1;
    end
    return prf;
  endfunction

  assign bus.prf_raddr_0 = bus.op0PAddr_0;
  assign bus.prf_raddr_1 = bus.op1PAddr_0;
  assign bus.prf_raddr_2 = bus.op0PAddr_1;
  assign bus.prf_raddr_3 = bus.op1PAddr_1;

  // Depends only on registered valids and ex_ready so the issue unit can gate issue_en on it.
  assign rr_ready     = ~(|ex_valid_q) | bus.ex_ready;
  assign bus.rr_ready = rr_ready;

  always_comb begin
    src0_sel[0] = bypass(bus.op0PAddr_0, bus.prf_rdata_0);
    src1_sel[0] = bus.useImm_0 ? bus.imm_0 : bypass(bus.op1PAddr_0, bus.prf_rdata_1);
    src0_sel[1] = bypass(bus.op0PAddr_1, bus.prf_rdata_2);
    src1_sel[1] = bus.useImm_1 ? bus.imm_1 : bypass(bus.op1PAddr_1, bus.prf_rdata_3);
  end

  always_comb begin
    ex_valid_d = ex_valid_q;
    ex_dstwe_d = ex_dstwe_q;
    ex_src0_d  = ex_src0_q;
    ex_src1_d  = ex_src1_q;
    ex_dst_d   = ex_dst_q;
    ex_pc_d    = ex_pc_q;
    ex_aluop_d = ex_aluop_q;
    if (rr_ready) begin
      ex_valid_d    = {bus.issue_en_1, bus.issue_en_0};
      ex_dstwe_d    = {bus.dstwe_1, bus.dstwe_0};
      ex_src0_d     = src0_sel;
      ex_src1_d     = src1_sel;
      ex_dst_d[0]   = bus.dstPAddr_0;
      ex_dst_d[1]   = bus.dstPAddr_1;
      ex_pc_d[0]    = bus.pc_0;
      ex_pc_d[1]    = bus.pc_1;
      ex_aluop_d[0] = bus.aluop_0;
      ex_aluop_d[1] = bus.aluop_1;
    end
    // Flush only kills the valids; the payload fields are don't-care once invalid.
    if (bus.flush) begin
      ex_valid_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid_q <= '0;
      ex_dstwe_q <= '0;
      ex_src0_q  <= '{default: '0};
      ex_src1_q  <= '{default: '0};
      ex_dst_q   <= '{default: '0};
      ex_pc_q    <= '{default: '0};
      ex_aluop_q <= '{default: '0};
    end else begin
      ex_valid_q <= ex_valid_d;
      ex_dstwe_q <= ex_dstwe_d;
      ex_src0_q  <= ex_src0_d;
      ex_src1_q  <= ex_src1_d;
      ex_dst_q   <= ex_dst_d;
      ex_pc_q    <= ex_pc_d;
      ex_aluop_q <= ex_aluop_d;
    end
  end

  assign bus.ex_valid_0 = ex_valid_q[0];
  assign bus.ex_valid_1 = ex_valid_q[1];
  assign bus.ex_dstwe_0 = ex_dstwe_q[0];
  assign bus.ex_dstwe_1 = ex_dstwe_q[1];
  assign bus.ex_src0_0  = ex_src0_q[0];
  assign bus.ex_src0_1  = ex_src0_q[1];
  assign bus.ex_src1_0  = ex_src1_q[0];
  assign bus.ex_src1_1  = ex_src1_q[1];
  assign bus.ex_dst_0   = ex_dst_q[0];
  assign bus.ex_dst_1   = ex_dst_q[1];
  assign bus.ex_pc_0    = ex_pc_q[0];
  assign bus.ex_pc_1    = ex_pc_q[1];
  assign bus.ex_aluop_0 = ex_aluop_q[0];
  assign bus.ex_aluop_1 = ex_aluop_q[1];

endmodule

// File: tb/tb_alu_regread_stage.sv
// Directed bench for alu_regread_stage: reset, plain read, bypass priority, immediate,
// stall hold, flush and asynchronous reset.
module tb_alu_regread_stage;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_fail;

  alu_regread_stage_if bus ();

  alu_regread_stage dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issuing into a stage that is not ready is a protocol violation.
  always @(posedge clk) begin
    if (rst_n && (bus.issue_en_0 || bus.issue_en_1) && !bus.rr_ready) begin
      n_fail++;
      $error("FAIL issue_while_stalled: issue_en=%b%b rr_ready=%b required no issue",
             bus.issue_en_1, bus.issue_en_0, bus.rr_ready);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    bus.flush = 0;
    bus.issue_en_0 = 0; bus.issue_en_1 = 0;
    bus.op0PAddr_0 = 0; bus.op0PAddr_1 = 0; bus.op1PAddr_0 = 0; bus.op1PAddr_1 = 0;
    bus.dstPAddr_0 = 0; bus.dstPAddr_1 = 0; bus.dstwe_0 = 0; bus.dstwe_1 = 0;
    bus.pc_0 = 0; bus.pc_1 = 0; bus.aluop_0 = 0; bus.aluop_1 = 0;
    bus.imm_0 = 0; bus.imm_1 = 0; bus.useImm_0 = 0; bus.useImm_1 = 0;
    bus.prf_rdata_0 = 0; bus.prf_rdata_1 = 0; bus.prf_rdata_2 = 0; bus.prf_rdata_3 = 0;
    bus.wb_en_0 = 0; bus.wb_en_1 = 0; bus.wb_addr_0 = 0; bus.wb_addr_1 = 0;
    bus.wb_data_0 = 0; bus.wb_data_1 = 0;
    bus.ex_ready = 0;

    // Reset
    #12;
    chk("rst_valid0", bus.ex_valid_0, 0);
    chk("rst_valid1", bus.ex_valid_1, 0);
    chk("rst_src0_0", bus.ex_src0_0, 0);
    chk("rst_src1_1", bus.ex_src1_1, 0);
    chk("rst_dst0",   bus.ex_dst_0, 0);
    chk("rst_pc1",    bus.ex_pc_1, 0);
    chk("rst_aluop0", bus.ex_aluop_0, 0);
    chk("rst_dstwe1", bus.ex_dstwe_1, 0);
    rst_n = 1'b1;
    bus.ex_ready = 1;
    #1;
    chk("rst_rr_ready", bus.rr_ready, 1);

    // Plain read, lane0 only
    bus.issue_en_0 = 1;
    bus.op0PAddr_0 = 3; bus.op1PAddr_0 = 4; bus.dstPAddr_0 = 5; bus.dstwe_0 = 1;
    bus.pc_0 = 32'h100; bus.aluop_0 = 2;
    bus.prf_rdata_0 = 32'h11; bus.prf_rdata_1 = 32'h22;
    #1;
    chk("raddr0", bus.prf_raddr_0, 3);
    chk("raddr1", bus.prf_raddr_1, 4);
    step();
    chk("plain_valid0", bus.ex_valid_0, 1);
    chk("plain_valid1", bus.ex_valid_1, 0);
    chk("plain_src0",   bus.ex_src0_0, 32'h11);
    chk("plain_src1",   bus.ex_src1_0, 32'h22);
    chk("plain_dst",    bus.ex_dst_0, 5);
    chk("plain_dstwe",  bus.ex_dstwe_0, 1);
    chk("plain_pc",     bus.ex_pc_0, 32'h100);
    chk("plain_aluop",  bus.ex_aluop_0, 2);

    // Bypass on lane1: op1 via port0, op0 via port1
    bus.issue_en_0 = 0; bus.issue_en_1 = 1;
    bus.op0PAddr_1 = 7; bus.op1PAddr_1 = 5;
    bus.prf_rdata_2 = 32'h77; bus.prf_rdata_3 = 32'hDEAD;
    bus.wb_en_0 = 1; bus.wb_addr_0 = 5; bus.wb_data_0 = 32'hAB;
    bus.wb_en_1 = 1; bus.wb_addr_1 = 7; bus.wb_data_1 = 32'h99;
    #1;
    chk("raddr3", bus.prf_raddr_3, 5);
    step();
    chk("byp_valid0", bus.ex_valid_0, 0);
    chk("byp_valid1", bus.ex_valid_1, 1);
    chk("byp_src1_p0", bus.ex_src1_1, 32'hAB);
    chk("byp_src0_p1", bus.ex_src0_1, 32'h99);

    // Both ports hit register 5: port0 wins; op0 falls back to the PRF
    bus.wb_addr_1 = 5; bus.wb_data_1 = 32'hCD;
    step();
    chk("byp_prio",  bus.ex_src1_1, 32'hAB);
    chk("byp_nohit", bus.ex_src0_1, 32'h77);

    // Immediate overrides a matching bypass
    bus.useImm_1 = 1; bus.imm_1 = 32'h7;
    step();
    chk("imm_src1", bus.ex_src1_1, 32'h7);
    bus.useImm_1 = 0; bus.wb_en_0 = 0; bus.wb_en_1 = 0;

    // Stall: capture lane0, then hold through 3 edges with changing inputs
    bus.issue_en_0 = 1; bus.issue_en_1 = 0;
    bus.prf_rdata_0 = 32'h55; bus.prf_rdata_1 = 32'h66; bus.dstPAddr_0 = 9;
    step();
    chk("stall_cap_src0", bus.ex_src0_0, 32'h55);
    bus.issue_en_0 = 0; bus.ex_ready = 0;
    bus.prf_rdata_0 = 32'hBAD;
    bus.wb_en_0 = 1; bus.wb_addr_0 = 4; bus.wb_data_0 = 32'hEE;
    #1;
    chk("stall_rr_ready", bus.rr_ready, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_valid0", bus.ex_valid_0, 1);
      chk("hold_src0",   bus.ex_src0_0, 32'h55);
      chk("hold_src1",   bus.ex_src1_0, 32'h66);
      chk("hold_dst",    bus.ex_dst_0, 9);
      bus.prf_rdata_0 = bus.prf_rdata_0 + 32'h1;
    end
    bus.wb_en_0 = 0;
    bus.ex_ready = 1;
    #1;
    chk("release_rr_ready", bus.rr_ready, 1);
    bus.issue_en_0 = 1; bus.prf_rdata_0 = 32'h12; bus.dstPAddr_0 = 10;
    step();
    chk("release_src0", bus.ex_src0_0, 32'h12);
    chk("release_dst",  bus.ex_dst_0, 10);

    // Flush dominates a simultaneous issue
    bus.flush = 1; bus.issue_en_0 = 1; bus.issue_en_1 = 1;
    step();
    chk("flush_valid0", bus.ex_valid_0, 0);
    chk("flush_valid1", bus.ex_valid_1, 0);
    bus.flush = 0; bus.issue_en_1 = 0;

    // Flush during a stall
    step();
    chk("pre_fs_valid0", bus.ex_valid_0, 1);
    bus.issue_en_0 = 0; bus.ex_ready = 0;
    #1;
    chk("fs_rr_ready_lo", bus.rr_ready, 0);
    bus.flush = 1;
    step();
    chk("fs_valid0", bus.ex_valid_0, 0);
    chk("fs_rr_ready_hi", bus.rr_ready, 1);
    bus.flush = 0;

    // Asynchronous reset between edges while lane1 is stalled valid
    bus.issue_en_1 = 1; bus.pc_1 = 32'h200;
    step();
    chk("pre_ar_valid1", bus.ex_valid_1, 1);
    chk("pre_ar_pc1",    bus.ex_pc_1, 32'h200);
    bus.issue_en_1 = 0;
    #3;
    rst_n = 1'b0;
    #1;
    chk("ar_valid1",   bus.ex_valid_1, 0);
    chk("ar_pc1",      bus.ex_pc_1, 0);
    chk("ar_rr_ready", bus.rr_ready, 1);
    #2;
    rst_n = 1'b1;
    step();
    chk("post_ar_valid1", bus.ex_valid_1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
